// File: rtl/regfile_mp_sb.sv
// Decode register file: NUM_RD combinational bypassed reads, ALU/link + memory write ports, load scoreboard.
// Reads are 0-cycle; writes/issues commit at the clock edge; iss_ready low rejects a re-issue to a pending register.
module regfile_mp_sb #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter int                 NUM_RD   = 2,
    parameter int                 SP_INDEX = 29,
    parameter logic [DATA_W-1:0]  SP_INIT  = 32'h0000_FFFC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    logic              en_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              a_wr;
    logic              b_wr;
    logic              wb_hits_iss;

    // JAL hijacks port A so the link register write never competes with the ALU result.
    always_comb begin
        en_a   = wa_en;
        addr_a = wa_addr;
        data_a = wa_data;
        if (link_en) begin
            en_a   = 1'b1;
            addr_a = '1;
            data_a = link_data;
        end
    end

    always_comb begin
        a_wr          = en_a && (addr_a != '0);
        wr_conflict_d = a_wr && wb_en && (wb_addr == addr_a);
        b_wr          = wb_en && (wb_addr != '0) && !wr_conflict_d;

        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (b_wr) regs_d[wb_addr] = wb_data;
        if (a_wr) regs_d[addr_a]  = data_a;
        regs_d[0] = '0;
    end

    always_comb begin
        wb_hits_iss = wb_en && (wb_addr == iss_addr);
        iss_ready   = !busy_q[iss_addr] || wb_hits_iss;

        // Clear first so a same-cycle issue to the retiring register leaves it busy.
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (iss_en && iss_ready) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            if (ra == '0) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
            end else if (en_a && (addr_a == ra)) begin
                rd_data[p*DATA_W +: DATA_W] = data_a;
            end else if (wb_en && (wb_addr == ra)) begin
                rd_data[p*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[p*DATA_W +: DATA_W] = regs_q[ra];
            end
            rd_busy[p] = busy_q[ra] && !(wb_en && (wb_addr == ra));
        end
    end

    assign wr_conflict = wr_conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares them.
module tb_regfile_mp_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        link_en;
    logic [31:0] link_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        wr_conflict;

    regfile_mp_sb dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .link_en(link_en), .link_data(link_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wr_conflict(wr_conflict)
    );

    always #5 clock = ~clock;

    localparam int K_RD0 = 0, K_RD1 = 1, K_BSY0 = 2, K_BSY1 = 3, K_IRDY = 4, K_CONF = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD0:   return rd_data[31:0];
            K_RD1:   return rd_data[63:32];
            K_BSY0:  return {31'b0, rd_busy[0]};
            K_BSY1:  return {31'b0, rd_busy[1]};
            K_IRDY:  return {31'b0, iss_ready};
            default: return {31'b0, wr_conflict};
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_RD0:   return "rd_data0";
            K_RD1:   return "rd_data1";
            K_BSY0:  return "rd_busy0";
            K_BSY1:  return "rd_busy1";
            K_IRDY:  return "iss_ready";
            default: return "wr_conflict";
        endcase
    endfunction

    // Monitor: every outstanding expectation refers to the outputs of the current cycle.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.kind);
            checks++;
            if (a === e.val) passed++;
            else $display("FAIL %s @%0t: got %h expected %h", kname(e.kind), $time, a, e.val);
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v);
        sb.push_back('{kind, v});
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
        reset   = 1'b0;
        wa_en   = 1'b0;
        link_en = 1'b0;
        wb_en   = 1'b0;
        iss_en  = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd_addr = '0;
        wa_en = 0; wa_addr = 0; wa_data = 0; link_en = 0; link_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; iss_en = 0; iss_addr = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset image: all zero except SP.
        for (int a = 0; a < 32; a += 2) begin
            set_rd(5'(a), 5'(a + 1));
            iss_addr = 5'(a + 1);
            expect_v(K_RD0, (a == 29) ? 32'h0000_FFFC : 32'h0);
            expect_v(K_RD1, (a + 1 == 29) ? 32'h0000_FFFC : 32'h0);
            expect_v(K_BSY0, 0);
            expect_v(K_BSY1, 0);
            expect_v(K_IRDY, 1);
            expect_v(K_CONF, 0);
            next_cyc();
        end

        // Port A bypass and register 0.
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEAD_BEEF; set_rd(5, 0);
        expect_v(K_RD0, 32'hDEAD_BEEF); expect_v(K_RD1, 0);
        next_cyc();
        wa_en = 1; wa_addr = 0; wa_data = 32'h1234; set_rd(5, 0);
        expect_v(K_RD0, 32'hDEAD_BEEF); expect_v(K_RD1, 0);
        next_cyc();
        set_rd(0, 5);
        expect_v(K_RD0, 0); expect_v(K_RD1, 32'hDEAD_BEEF);
        next_cyc();

        // Port B bypass alone.
        wb_en = 1; wb_addr = 10; wb_data = 32'h77; set_rd(0, 10);
        expect_v(K_RD1, 32'h77);
        next_cyc();
        set_rd(0, 10);
        expect_v(K_RD1, 32'h77);
        next_cyc();

        // Same-index A/B conflict: A wins, one-cycle registered pulse.
        wa_en = 1; wa_addr = 7; wa_data = 32'hA; wb_en = 1; wb_addr = 7; wb_data = 32'hB;
        set_rd(7, 7);
        expect_v(K_RD0, 32'hA); expect_v(K_CONF, 0);
        next_cyc();
        set_rd(7, 0);
        expect_v(K_RD0, 32'hA); expect_v(K_CONF, 1);
        next_cyc();
        wa_en = 1; wa_addr = 0; wb_en = 1; wb_addr = 0;
        expect_v(K_CONF, 0);
        next_cyc();
        expect_v(K_CONF, 0);
        next_cyc();

        // JAL overrides the ALU write.
        link_en = 1; link_data = 32'h0040_0008; wa_en = 1; wa_addr = 3; wa_data = 32'h33;
        set_rd(3, 31);
        expect_v(K_RD0, 0); expect_v(K_RD1, 32'h0040_0008);
        next_cyc();
        set_rd(3, 31);
        expect_v(K_RD0, 0); expect_v(K_RD1, 32'h0040_0008);
        next_cyc();

        // Load-use scoreboard.
        iss_en = 1; iss_addr = 8; set_rd(8, 8);
        expect_v(K_IRDY, 1); expect_v(K_BSY0, 0);
        next_cyc();
        iss_en = 1; iss_addr = 8; set_rd(8, 8);
        expect_v(K_IRDY, 0); expect_v(K_BSY0, 1); expect_v(K_BSY1, 1);
        next_cyc();
        wb_en = 1; wb_addr = 8; wb_data = 32'h55; iss_addr = 8; set_rd(8, 0);
        expect_v(K_BSY0, 0); expect_v(K_RD0, 32'h55); expect_v(K_IRDY, 1);
        next_cyc();
        iss_addr = 8; set_rd(8, 0);
        expect_v(K_BSY0, 0); expect_v(K_RD0, 32'h55); expect_v(K_IRDY, 1);
        next_cyc();

        // Issue and retire of the same index: the new load stays pending.
        iss_en = 1; iss_addr = 9; set_rd(9, 0);
        expect_v(K_IRDY, 1);
        next_cyc();
        wb_en = 1; wb_addr = 9; wb_data = 32'h99; iss_en = 1; iss_addr = 9; set_rd(9, 0);
        expect_v(K_IRDY, 1); expect_v(K_BSY0, 0); expect_v(K_RD0, 32'h99);
        next_cyc();
        iss_addr = 9; set_rd(9, 0);
        expect_v(K_BSY0, 1); expect_v(K_RD0, 32'h99); expect_v(K_IRDY, 0);
        next_cyc();

        // Reset mid-operation beats the concurrent write.
        reset = 1; wa_en = 1; wa_addr = 4; wa_data = 32'h44;
        next_cyc();
        iss_addr = 9; set_rd(9, 4);
        expect_v(K_BSY0, 0); expect_v(K_RD0, 0); expect_v(K_RD1, 0);
        expect_v(K_IRDY, 1); expect_v(K_CONF, 0);
        next_cyc();
        set_rd(29, 8);
        expect_v(K_RD0, 32'h0000_FFFC); expect_v(K_RD1, 0);
        next_cyc();
        next_cyc();

        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
